vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing.
- Produces a pixel clock-enable, free-running x/y scan counters, video_on, and registered active-low hsync/vsync.
- Drives the x, y and video_on inputs of pixel_gen and the board sync pins.
- x/y sweep the full 800x525 raster, including blanking, so downstream logic can key events to blanking coordinates (e.g. y==481, x==0).

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pixel_tick_div.sv | 27 ++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants, derived raster/sync bounds and the
// coordinate type shared by the scan counters and downstream pixel logic.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: p_tick is high for one clk out of every CLK_DIV,
// decoded straight from the counter so it is valid during reset as well.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster scan counters with registered active-low hsync/vsync and frame pulse.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic   clk,
    input  logic   reset,
    output logic   p_tick,
    output coord_t x,
    output coord_t y,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;
    logic   wrap;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    assign wrap = p_tick && (x == H_LAST) && (y == V_LAST);

    // Syncs decode the next-state coordinates so they register alongside x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            x           <= x_next;
            y           <= y_next;
            hsync       <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync       <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            frame_start <= wrap;
        end
    end

    assign video_on = (x < H_VIS) && (y < V_VIS);

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else if (wrap)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    // No frame counter in this build; wrap only drives frame_start.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x525 raster at CLK_DIV=4 and a shrunken
// 96x60 raster at CLK_DIV=1, both checked every clk against an arithmetic model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        p_tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        frame_start;
        logic [15:0] frame_cnt;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic       a_p_tick, a_video_on, a_hsync, a_vsync, a_frame_start;
    logic [9:0] a_x, a_y;
    logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_frame_start;
    logic [9:0] b_x, b_y;
    logic [15:0] a_frame_cnt, b_frame_cnt;

    vga_timing_gen dut_a (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (a_p_tick),
        .x           (a_x),
        .y           (a_y),
        .video_on    (a_video_on),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .frame_start (a_frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt   (a_frame_cnt)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV   (1),
        .H_DISPLAY (64),
        .H_FRONT   (8),
        .H_SYNC    (16),
        .H_BACK    (8),
        .V_DISPLAY (48),
        .V_FRONT   (4),
        .V_SYNC    (2),
        .V_BACK    (6)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (b_p_tick),
        .x           (b_x),
        .y           (b_y),
        .video_on    (b_video_on),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .frame_start (b_frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt   (b_frame_cnt)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign a_frame_cnt = 16'd0;
    assign b_frame_cnt = 16'd0;
`endif

    // Expected outputs after k clk edges since reset release, from raster arithmetic.
    function automatic obs_t model(input int k, input int d,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        obs_t o;
        int ht, vt, ft, n, px, py;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        ft = ht * vt;
        n  = k / d;
        px = n % ht;
        py = (n / ht) % vt;
        o.p_tick      = ((k % d) == d - 1);
        o.x           = 10'(px);
        o.y           = 10'(py);
        o.video_on    = (px < hd) && (py < vd);
        o.hsync       = !((px >= hd + hf) && (px < hd + hf + hs));
        o.vsync       = !((py >= vd + vf) && (py < vd + vf + vs));
        o.frame_start = (k > 0) && ((k % d) == 0) && ((n % ft) == 0);
`ifdef VGA_FRAME_COUNT_EN
        o.frame_cnt   = 16'((n / ft) % 65536);
`else
        o.frame_cnt   = 16'd0;
`endif
        return o;
    endfunction

    obs_t q_a[$];
    obs_t q_b[$];
    int   k = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got p=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b fc=%0d | exp p=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fs=%0b fc=%0d",
                     name, cyc, got.p_tick, got.x, got.y, got.video_on, got.hsync, got.vsync,
                     got.frame_start, got.frame_cnt, exp.p_tick, exp.x, exp.y, exp.video_on,
                     exp.hsync, exp.vsync, exp.frame_start, exp.frame_cnt);
        end
    endtask

    // Monitor: samples away from the active edge and pops one expectation per DUT.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (q_a.size() > 0 && q_b.size() > 0) begin
                obs_t ga, gb, ea, eb;
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                ga = '{a_p_tick, a_x, a_y, a_video_on, a_hsync, a_vsync, a_frame_start, a_frame_cnt};
                gb = '{b_p_tick, b_x, b_y, b_video_on, b_hsync, b_vsync, b_frame_start, b_frame_cnt};
                compare("raster800_div4", ga, ea);
                compare("raster96_div1", gb, eb);
            end
        end
    end

    // One clk of stimulus: advance the model on the edge, then set reset between edges.
    task automatic step(input logic r);
        @(posedge clk);
        if (!reset) k++;
        @(negedge clk);
        reset = r;
        if (reset) k = 0;
        cyc++;
        q_a.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q_b.push_back(model(k, 1, 64, 8, 16, 8, 48, 4, 2, 6));
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1);
        // Long run: several lines of the full raster and three-plus small frames.
        for (int i = 0; i < 20000; i++) step(1'b0);
        for (int seg = 0; seg < 8; seg++) begin
            int hold, run;
            hold = $urandom_range(3, 1);
            run  = $urandom_range(3000, 50);
            for (int i = 0; i < hold; i++) step(1'b1);
            for (int i = 0; i < run; i++) step(1'b0);
        end
        @(negedge clk);
        #3;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expectations, required 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
